// File: rtl/led_strand_pkg.sv
// Shared types and default timing for the WS2812 strand driver.
// Defaults assume the 100 MHz board clock.
package led_strand_pkg;

    typedef enum logic [2:0] {
        LATCH,
        FETCH_WAIT,
        FETCH,
        BIT_HIGH,
        BIT_LOW
    } strand_state_t;

    localparam int DEF_T0H_CYCLES   = 40;
    localparam int DEF_T0L_CYCLES   = 85;
    localparam int DEF_T1H_CYCLES   = 80;
    localparam int DEF_T1L_CYCLES   = 45;
    localparam int DEF_LATCH_CYCLES = 5000;

    typedef struct packed {
        logic [7:0] green;
        logic [7:0] red;
        logic [7:0] blue;
    } grb_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_strand_driver_bit_encoder.sv
// Single-bit WS2812 waveform generator: high phase then low phase.
// A start on the done cycle chains bits back to back.
module ws2812_bit_encoder #(
    parameter int T0H_CYCLES = 40,
    parameter int T0L_CYCLES = 85,
    parameter int T1H_CYCLES = 80,
    parameter int T1L_CYCLES = 45,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_val,
    output logic strand_out,
    output logic high_done,
    output logic done
);

    logic             busy_q;
    logic             high_q;
    logic             bit_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            high_q <= 1'b0;
            bit_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            high_q <= 1'b1;
            bit_q  <= bit_val;
            cnt_q  <= bit_val ? CNT_W'(T1H_CYCLES - 1)
                              : CNT_W'(T0H_CYCLES - 1);
        end else if (busy_q) begin
            if (!cnt_zero) begin
                cnt_q <= cnt_q - 1'b1;
            end else if (high_q) begin
                high_q <= 1'b0;
                cnt_q  <= bit_q ? CNT_W'(T1L_CYCLES - 1)
                                : CNT_W'(T0L_CYCLES - 1);
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign strand_out = high_q;
    assign high_done  = busy_q & high_q & cnt_zero;
    assign done       = busy_q & ~high_q & cnt_zero;

endmodule

// File: rtl/ws2812_strand_driver.sv
// Walks LED addresses, fetches GRB colours and serializes them MSB first,
// with a latch gap between frames.
module ws2812_strand_driver
    import led_strand_pkg::*;
#(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    parameter int T0H_CYCLES        = DEF_T0H_CYCLES,
    parameter int T0L_CYCLES        = DEF_T0L_CYCLES,
    parameter int T1H_CYCLES        = DEF_T1H_CYCLES,
    parameter int T1L_CYCLES        = DEF_T1L_CYCLES,
    parameter int LATCH_CYCLES      = DEF_LATCH_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [LED_ADDRESS_WIDTH-1:0] next_led_request,
    input  logic [7:0]                   green_in,
    input  logic [7:0]                   red_in,
    input  logic [7:0]                   blue_in,
    input  logic                         color_valid,
    output logic                         strand_out,
    output logic                         frame_done
);

    localparam int MAX_T = max_int(
        max_int(max_int(T0H_CYCLES, T0L_CYCLES),
                max_int(T1H_CYCLES, T1L_CYCLES)),
        LATCH_CYCLES);
    localparam int CNT_W = $clog2(MAX_T) + 1;
    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [LED_ADDRESS_WIDTH-1:0] LAST_LED =
        LED_ADDRESS_WIDTH'(NUM_LEDS - 1);

    strand_state_t                state_q, state_d;
    logic [CNT_W-1:0]             latch_cnt_q, latch_cnt_d;
    grb_t                         shift_q, shift_d;
    logic [4:0]                   bit_idx_q, bit_idx_d;
    logic [LED_ADDRESS_WIDTH-1:0] led_q, led_d;
    logic                         frame_done_q, frame_done_d;
    logic                         enc_start;
    logic                         enc_bit;
    logic                         enc_high_done;
    logic                         enc_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LATCH;
            latch_cnt_q  <= LATCH_LOAD;
            shift_q      <= '0;
            bit_idx_q    <= 5'd23;
            led_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            latch_cnt_q  <= latch_cnt_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            led_q        <= led_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        latch_cnt_d  = latch_cnt_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        led_d        = led_q;
        frame_done_d = 1'b0;
        enc_start    = 1'b0;
        enc_bit      = 1'b0;
        unique case (state_q)
            LATCH: begin
                if (latch_cnt_q == '0) state_d = FETCH_WAIT;
                else latch_cnt_d = latch_cnt_q - 1'b1;
            end
            FETCH_WAIT: state_d = FETCH;
            FETCH: begin
                if (color_valid) begin
                    shift_d   = '{green: green_in, red: red_in, blue: blue_in};
                    bit_idx_d = 5'd23;
                    enc_start = 1'b1;
                    enc_bit   = green_in[7];
                    state_d   = BIT_HIGH;
                end
            end
            BIT_HIGH: begin
                if (enc_high_done) state_d = BIT_LOW;
            end
            BIT_LOW: begin
                if (enc_done) begin
                    if (bit_idx_q != 5'd0) begin
                        // Next bit starts on the done cycle: no gap between bits.
                        shift_d   = shift_q << 1;
                        bit_idx_d = bit_idx_q - 5'd1;
                        enc_start = 1'b1;
                        enc_bit   = shift_q[22];
                        state_d   = BIT_HIGH;
                    end else if (led_q != LAST_LED) begin
                        led_d   = led_q + 1'b1;
                        state_d = FETCH_WAIT;
                    end else begin
                        frame_done_d = 1'b1;
                        led_d        = '0;
                        latch_cnt_d  = LATCH_LOAD;
                        state_d      = LATCH;
                    end
                end
            end
            default: state_d = LATCH;
        endcase
    end

    ws2812_bit_encoder #(
        .T0H_CYCLES (T0H_CYCLES),
        .T0L_CYCLES (T0L_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .T1L_CYCLES (T1L_CYCLES),
        .CNT_W      (CNT_W)
    ) u_enc (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (enc_start),
        .bit_val    (enc_bit),
        .strand_out (strand_out),
        .high_done  (enc_high_done),
        .done       (enc_done)
    );

    assign next_led_request = led_q;
    assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_ws2812_strand_driver.sv
// Directed bench for ws2812_strand_driver: 3 LEDs, short timings.
// Decodes strand pulses at negedges and compares against a colour table.
module tb_ws2812_strand_driver;

    localparam int N    = 3;
    localparam int T0H  = 2;
    localparam int T0L  = 4;
    localparam int T1H  = 4;
    localparam int T1L  = 2;
    localparam int LAT  = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] next_led_request;
    logic [7:0] green_in, red_in, blue_in;
    logic       color_valid;
    logic       strand_out;
    logic       frame_done;

    logic [23:0] colors [N];
    logic        garble;
    logic        tog_mode;
    logic        flip;
    int          n_checks = 0;
    int          n_err    = 0;

    always #5 clk = ~clk;

    ws2812_strand_driver #(
        .NUM_LEDS          (N),
        .LED_ADDRESS_WIDTH (2),
        .T0H_CYCLES        (T0H),
        .T0L_CYCLES        (T0L),
        .T1H_CYCLES        (T1H),
        .T1L_CYCLES        (T1L),
        .LATCH_CYCLES      (LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .next_led_request (next_led_request),
        .green_in         (green_in),
        .red_in           (red_in),
        .blue_in          (blue_in),
        .color_valid      (color_valid),
        .strand_out       (strand_out),
        .frame_done       (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Upstream colour source; garbles inputs while bits are on the wire.
    initial begin
        {green_in, red_in, blue_in} = 24'h0;
        flip = 1'b0;
        forever begin
            @(negedge clk);
            if (garble) begin
                flip = ~flip;
                {green_in, red_in, blue_in} =
                    flip ? ~colors[next_led_request] : 24'($urandom);
            end else begin
                {green_in, red_in, blue_in} = colors[next_led_request];
            end
        end
    end

    // Call at a negedge; returns at the first low sample of the last bit.
    task automatic rx_led(input int k);
        logic [23:0] e;
        logic [23:0] got;
        int n, hi, lo;
        e = colors[k];
        got = '0;
        n = 0;
        while (strand_out !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("L%0d start", k), n < 500, 1);
        if (n >= 500) return;
        chk($sformatf("L%0d req", k), next_led_request, k);
        garble = tog_mode;
        for (int i = 23; i >= 0; i--) begin
            hi = 0;
            while (strand_out === 1'b1 && hi < 20) begin
                hi++;
                @(negedge clk);
            end
            got[i] = (hi == T1H);
            chk($sformatf("L%0d b%0d hi", k, i), hi, e[i] ? T1H : T0H);
            if (i > 0) begin
                lo = 0;
                while (strand_out === 1'b0 && lo < 20) begin
                    lo++;
                    @(negedge clk);
                end
                chk($sformatf("L%0d b%0d lo", k, i), lo, e[i] ? T1L : T0L);
            end
        end
        garble = 1'b0;
        chk($sformatf("L%0d pixel", k), got, e);
    endtask

    // After the last LED: frame_done timing, then the latch gap.
    task automatic frame_end(input string tag);
        int n, fd;
        n = 0;
        while (frame_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " fd delay"}, n, colors[N-1][0] ? T1L : T0L);
        chk({tag, " req0"}, next_led_request, 0);
        n = 0;
        fd = 0;
        while (strand_out === 1'b0 && n < 100) begin
            if (frame_done === 1'b1) fd++;
            n++;
            @(negedge clk);
        end
        chk({tag, " fd width"}, fd, 1);
        chk({tag, " gap"}, n, LAT + 2);
    endtask

    task automatic after_release(input string tag);
        int n, bad;
        n = 0;
        bad = 0;
        @(negedge clk);
        while (strand_out === 1'b0 && n < 100) begin
            if (next_led_request !== 2'd0) bad++;
            n++;
            @(negedge clk);
        end
        chk({tag, " low cycles"}, n, LAT + 1);
        chk({tag, " req held"}, bad, 0);
    endtask

    initial begin
        int n, bad;
        colors[0] = 24'h00FF00;
        colors[1] = 24'hA53C81;
        colors[2] = 24'h81007E;
        garble = 1'b0;
        tog_mode = 1'b0;
        color_valid = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst strand", strand_out, 0);
        chk("rst req", next_led_request, 0);
        chk("rst fd", frame_done, 0);
        rst_n = 1'b1;
        after_release("init");

        rx_led(0);
        color_valid = 1'b0;
        n = 0;
        while (next_led_request !== 2'd1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold reach", n < 50, 1);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (strand_out !== 1'b0 || next_led_request !== 2'd1) bad++;
        end
        chk("hold quiet", bad, 0);
        color_valid = 1'b1;
        @(negedge clk);
        chk("resume", strand_out, 1);
        rx_led(1);
        rx_led(2);
        frame_end("f1");

        tog_mode = 1'b1;
        rx_led(0);
        rx_led(1);
        rx_led(2);
        frame_end("f2");
        tog_mode = 1'b0;

        chk("pre-rst high", strand_out, 1);
        rst_n = 1'b0;
        #1;
        chk("async strand", strand_out, 0);
        chk("async req", next_led_request, 0);
        chk("async fd", frame_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        after_release("mid");
        rx_led(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
